// File: rtl/nand_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nand_pipe_arbiter
// Purpose  : Round-robin arbiter in front of a shared, registered two-stage
//            NAND datapath. Stage 1 captures the granted operand pair and the
//            requester tag. Stage 2 registers ~(a & b) together with the tag.
//            hold freezes every register and blocks new grants.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            hold       - 1 = freeze pipeline, no grants
//            req        - per-requester request, held until granted
//            a_in, b_in - packed operands, slice i belongs to requester i
//            gnt        - one-hot combinational grant
//            q_out      - registered NAND result
//            rsp_valid  - q_out / rsp_id valid
//            rsp_id     - requester index owning q_out
//            inflight   - number of valid pipeline stages (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module nand_pipe_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     hold,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         q_out,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [1:0]               inflight
);

    localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    // Registered state
    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [ID_W-1:0]  r_s1_id;
    logic [WIDTH-1:0] r_q;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [1:0]       r_inflight;

    // Combinational
    logic             w_allow;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W:0]    w_cand;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [ID_W-1:0]  w_next_ptr;

    // Grants are suppressed during reset as well as during hold, so nothing
    // is advertised as accepted while the pipeline cannot capture it.
    assign w_allow = reset_n & ~hold;

    // Rotating search starting at r_ptr. The candidate is one bit wider than
    // the tag so the wrap can be done with a single conditional subtract.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (!w_grant_any && req[w_cand[ID_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_cand[ID_W-1:0];
            end
        end
        if (!w_allow) begin
            w_grant_any = 1'b0;
        end
    end

    always_comb begin
        gnt = '0;
        if (w_grant_any) begin
            gnt = NUM_REQ'(1) << w_grant_id;
        end
    end

    // Operand mux on the granted index
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_a = a_in[i*WIDTH +: WIDTH];
                w_sel_b = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_grant_id == c_last_id) ? '0 : (w_grant_id + ID_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_id     <= '0;
            r_q         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_inflight  <= 2'd0;
        end else if (!hold) begin
            r_s1_valid  <= w_grant_any;
            r_rsp_valid <= r_s1_valid;
            // Occupancy after this edge: new stage-1 entry plus the entry
            // moving from stage 1 into the output stage.
            r_inflight  <= {1'b0, w_grant_any} + {1'b0, r_s1_valid};
            if (w_grant_any) begin
                r_ptr   <= w_next_ptr;
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_grant_id;
            end
            // Result and tag persist when stage 1 is empty; only the valid
            // flag drops.
            if (r_s1_valid) begin
                r_q      <= ~(r_s1_a & r_s1_b);
                r_rsp_id <= r_s1_id;
            end
        end
    end

    assign q_out     = r_q;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_nand_pipe_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nand_pipe_arbiter
// Purpose  : Self-checking bench for nand_pipe_arbiter: a directed vector
//            table, an asynchronous-reset sequence, and a randomized phase
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_pipe_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           hold;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q_out;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [1:0]     inflight;

    int errors = 0;
    int checks = 0;

    nand_pipe_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .q_out     (q_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic           hold;
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   exp_gnt;
        logic           exp_rv;
        logic [W-1:0]   exp_q;
        logic [IW-1:0]  exp_id;
        logic [1:0]     exp_inf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic h, input logic [N-1:0] r,
                                input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                input logic [N-1:0] g, input logic rv,
                                input logic [W-1:0] q, input logic [IW-1:0] id,
                                input logic [1:0] inf);
        vec_t v;
        v.hold = h; v.req = r; v.a = a; v.b = b;
        v.exp_gnt = g; v.exp_rv = rv; v.exp_q = q; v.exp_id = id; v.exp_inf = inf;
        return v;
    endfunction

    // ------------------------------------------------------ reference model
    // Time advances only on unfrozen edges (m_n). An op accepted on unfrozen
    // edge g is the visible response while m_n == g+1.
    typedef struct {
        int           g;
        int           id;
        logic [W-1:0] q;
    } op_t;

    op_t          ops[$];
    int           m_ptr;
    int           m_n;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic [N-1:0] pend;

    function automatic int model_pick(input logic [N-1:0] r, input logic h, input int ptr);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ops.delete();
        m_ptr = 0;
        m_n   = 0;
    endtask

    task automatic rand_cycle();
        int           pick;
        logic         e_rv;
        logic [1:0]   e_inf;
        logic [W-1:0] e_q;
        int           e_id;
        logic         found;
        logic [N-1:0] e_gnt;
        hold = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
                pend[i] = 1'b1;
                opa[i]  = W'($urandom);
                opb[i]  = W'($urandom);
            end
            a_in[i*W +: W] = opa[i];
            b_in[i*W +: W] = opb[i];
        end
        req  = pend;
        pick = model_pick(req, hold, m_ptr);
        e_gnt = (pick < 0) ? '0 : (N'(1) << pick);
        e_rv = 1'b0; e_inf = 2'd0; e_q = '0; e_id = 0; found = 1'b0;
        foreach (ops[k]) begin
            if (ops[k].g == m_n - 1) e_rv = 1'b1;
            if (ops[k].g == m_n || ops[k].g == m_n - 1) e_inf = e_inf + 2'd1;
        end
        for (int k = ops.size() - 1; k >= 0; k--) begin
            if (!found && ops[k].g <= m_n - 1) begin
                found = 1'b1;
                e_q   = ops[k].q;
                e_id  = ops[k].id;
            end
        end
        @(negedge clk);
        check("rnd_gnt",      gnt,       e_gnt);
        check("rnd_rsp_valid", rsp_valid, e_rv);
        check("rnd_q_out",    q_out,     e_q);
        check("rnd_rsp_id",   rsp_id,    e_id);
        check("rnd_inflight", inflight,  e_inf);
        @(posedge clk);
        if (!hold) begin
            m_n++;
            if (pick >= 0) begin
                op_t o;
                o.g  = m_n;
                o.id = pick;
                o.q  = ~(opa[pick] & opb[pick]);
                ops.push_back(o);
                m_ptr = (pick + 1) % N;
                pend[pick] = 1'b0;
            end
            while (ops.size() > 3) void'(ops.pop_front());
        end
        #1;
    endtask

    // ------------------------------------------------------------ stimulus
    localparam logic [N*W-1:0] C_A0 = 32'h0000_00F0;
    localparam logic [N*W-1:0] C_B0 = 32'h0000_003C;
    // slices 3..0: A = FF,3C,AA,00  B = FF,0F,0F,AA -> q = 00,F3,F5,FF
    localparam logic [N*W-1:0] C_AS = 32'hFF3C_AA00;
    localparam logic [N*W-1:0] C_BS = 32'hFF0F_0FAA;

    initial begin
        reset_n = 1'b0;
        hold    = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        pend    = '0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        model_reset();

        tbl.push_back(mk(0, 4'b0001, C_A0, C_B0, 4'b0001, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 4'b0000, C_A0, C_B0, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b0000, C_A0, C_B0, 4'b0000, 1, 8'hCF, 0, 1));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 0, 8'hCF, 0, 0));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0010, 0, 8'hCF, 0, 0));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0100, 0, 8'hCF, 0, 1));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b1000, 1, 8'hF5, 1, 2));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0001, 1, 8'hF3, 2, 2));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0010, 1, 8'h00, 3, 2));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0100, 1, 8'hFF, 0, 2));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b1000, 1, 8'hF5, 1, 2));
        tbl.push_back(mk(0, 4'b1111, C_AS, C_BS, 4'b0001, 1, 8'hF3, 2, 2));
        tbl.push_back(mk(1, 4'b1111, C_AS, C_BS, 4'b0000, 1, 8'h00, 3, 2));
        tbl.push_back(mk(1, 4'b1111, C_AS, C_BS, 4'b0000, 1, 8'h00, 3, 2));
        tbl.push_back(mk(1, 4'b1111, C_AS, C_BS, 4'b0000, 1, 8'h00, 3, 2));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 1, 8'h00, 3, 2));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 4'b0010, C_AS, C_BS, 4'b0010, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 4'b0011, C_AS, C_BS, 4'b0001, 0, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 4'b0010, C_AS, C_BS, 4'b0010, 1, 8'hF5, 1, 2));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 1, 8'hFF, 0, 2));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 1, 8'hF5, 1, 1));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 0, 8'hF5, 1, 0));
        tbl.push_back(mk(1, 4'b0100, C_AS, C_BS, 4'b0000, 0, 8'hF5, 1, 0));
        tbl.push_back(mk(0, 4'b0100, C_AS, C_BS, 4'b0100, 0, 8'hF5, 1, 0));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 0, 8'hF5, 1, 1));
        tbl.push_back(mk(0, 4'b0000, C_AS, C_BS, 4'b0000, 1, 8'hF3, 2, 1));

        // Reset state, with a request present to show gnt is forced low
        req = 4'b0001;
        @(negedge clk);
        check("rst_gnt",       gnt,       0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_q_out",     q_out,     0);
        check("rst_rsp_id",    rsp_id,    0);
        check("rst_inflight",  inflight,  0);
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        foreach (tbl[r]) begin
            hold = tbl[r].hold;
            req  = tbl[r].req;
            a_in = tbl[r].a;
            b_in = tbl[r].b;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", r),       gnt,       tbl[r].exp_gnt);
            check($sformatf("vec%0d_rsp_valid", r), rsp_valid, tbl[r].exp_rv);
            check($sformatf("vec%0d_q_out", r),     q_out,     tbl[r].exp_q);
            check($sformatf("vec%0d_rsp_id", r),    rsp_id,    tbl[r].exp_id);
            check($sformatf("vec%0d_inflight", r),  inflight,  tbl[r].exp_inf);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with both stages full (ptr is 3 here)
        hold = 1'b0;
        req  = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_inflight", inflight, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_gnt",       gnt,       0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_q_out",     q_out,     0);
        check("arst_rsp_id",    rsp_id,    0);
        check("arst_inflight",  inflight,  0);
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_inflight",  inflight,  0);
        end
        @(posedge clk); #1;
        // ptr back at 0 selects requester 0 rather than 3
        req = 4'b1001;
        #1;
        check("post_rst_ptr_gnt", gnt, 4'b0001);
        req = '0;

        // Randomized phase against the reference model
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        pend = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            rand_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
